ad7476a_responder: RTL and testbench
====================================

// Module: ad7476a_responder
// PURPOSE
//  Slave-side model of the AD7476A serial ADC port, synthesizable, in the clk_i domain.
//  Drives a 12-bit word from the FPGA fabric onto sdata_o when an SPI master toggles cs_n_i/sclk_i.
//  Used as loopback target for the ADC master on hardware and as its bench/formal partner.
//  Frame: 4 leading zeros then D11..D0, MSB first, 16 bits total.
// PARAMETERS
//  SYNC_STAGES    2   flops in each cs_n_i/sclk_i synchronizer (>=2)
//  LEADING_ZEROS  4   zero bits before data
//  DATA_BITS      12  data bits per frame
// PORTS
//  clk_i            in   1   system clock; all logic on posedge
//  rst_n_i          in   1   asynchronous active-low reset
//  sample_i         in   12  word to transmit; captured at frame start
//  sclk_i           in   1   SPI clock from master, async to clk_i, idles high
//  cs_n_i           in   1   SPI chip select from master, async, active-low
//  sdata_o          out  1   serial data; 0 whenever sdata_oe_o=0
//  sdata_oe_o       out  1   1 = drive pad, 0 = pad three-state
//  sample_taken_o   out  1   1-cycle pulse: sample_i captured
//  frame_done_o     out  1   1-cycle pulse: 16th sclk falling edge seen
//  abort_o          out  1   1-cycle pulse: cs_n_i rose before 16 falling edges
//  busy_o           out  1   1 while state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0; sync flops = 1 (idle levels).
//  Edges detected on synchronized signals only: fall = prev & ~cur. Pin-to-output latency
//   SYNC_STAGES+1 clk cycles; legal only for CLK_FREQ >= 4*SCLK_FREQ (documented, not checked).
//  shift reg sr[15:0], edge counter cnt[4:0] (0..16).
//  IDLE:     on cs fall: sr <= {LEADING_ZEROS'b0, sample_i}; cnt<=0; sample_taken_o=1;
//            sdata_oe_o<=1; sdata_o<=sr MSB (0) -> ACTIVE.
//  ACTIVE:   on sclk fall: cnt<=cnt+1; sr<=sr<<1; sdata_o<=next MSB.
//            when cnt reaches 16: frame_done_o=1, sdata_oe_o<=0, sdata_o<=0 -> TRAILING.
//            on cs rise (cnt<16): abort_o=1, oe<=0 -> IDLE.
//  TRAILING: ignore sclk; on cs rise -> IDLE. No second frame without cs rise.
//  Simultaneous cs rise and 16th sclk fall in ACTIVE: frame_done_o wins, abort_o=0, -> IDLE.
//  Simultaneous cs fall and sclk fall in IDLE: capture only; the sclk edge is not counted.
//  sclk edges while IDLE are ignored; sample_i is don't-care outside the capture cycle.
//  Bit n (n=0..15) is valid from the (n)th sclk fall (n=0: cs fall) + latency until the next fall.
//   The master samples on the rising edge.
//  rst_n_i asserted mid-frame: oe drops immediately (async); after release, wait in IDLE
//   for a fresh cs fall. A cs_n_i already low at release does not start a frame.
//  Pulse outputs are registered, exactly 1 cycle, never overlapping within one frame.
// STRUCTURE
//  ad7476a_defs.vh: FRAME_BITS=16, LEADING_ZEROS, DATA_BITS, state encodings
//   IDLE=2'd0, ACTIVE=2'd1, TRAILING=2'd2; shared with the master.
//  Sub-module sync_edge (SYNC_STAGES, RESET_VAL): synchronizer + rise/fall pulses.
//   Instantiated twice, for cs_n_i and sclk_i.
//  Top: FSM, 16-bit shift register, 5-bit counter, registered outputs.
// TESTING
//  1 Paired with ad7476a_interface (100MHz/20MHz), sample_i=12'hA5C, request pulse
//    -> data_o=12'hA5C, frame_done_o once, abort_o=0.
//  2 Back-to-back requests, sample_i 12'h000 then 12'hFFF
//    -> two frames; top 4 bits 0 each; sample_taken_o twice.
//  3 cs_n_i rises after 7 sclk falls -> abort_o pulse, oe=0 within SYNC_STAGES+2 cycles;
//    the next frame sends a fresh sample.
//  4 20 sclk falls in one frame -> oe=0 after the 16th; edges 17-20 ignored;
//    cs rise -> IDLE with no abort.
//  5 rst_n_i low at the 9th bit -> all outputs 0 asynchronously; with cs held low after
//    release, no frame starts until cs toggles.
//  6 sclk toggling with cs_n_i high -> sdata_oe_o stays 0, no pulses.

Source files
------------

// File: rtl/ad7476a_responder_pkg.sv
// Shared constants and types for the AD7476A slave-side responder.
// Frame geometry and state encodings are also used by the matching master.
package ad7476a_responder_pkg;
  localparam int DEF_LEADING_ZEROS = 4;
  localparam int DEF_DATA_BITS     = 12;
  localparam int DEF_FRAME_BITS    = DEF_LEADING_ZEROS + DEF_DATA_BITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_TRAILING = 2'd2
  } state_e;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } edge_t;
endpackage

// File: rtl/ad7476a_responder_sync_edge.sv
// Multi-flop synchronizer for one async pin plus registered-level edge pulses.
module ad7476a_responder_sync_edge
  import ad7476a_responder_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  async_i,
  output edge_t edge_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o.level = sync_q[SYNC_STAGES-1];
  assign edge_o.rise  = ~prev_q &  sync_q[SYNC_STAGES-1];
  assign edge_o.fall  =  prev_q & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/ad7476a_responder.sv
// AD7476A serial-port slave: shifts {zeros, sample_i} out MSB first on sclk falls
// while cs_n_i is low; all pin activity is oversampled in the clk_i domain.
module ad7476a_responder
  import ad7476a_responder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int LEADING_ZEROS = DEF_LEADING_ZEROS,
  parameter int DATA_BITS     = DEF_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DATA_BITS-1:0] sample_i,
  input  logic                 sclk_i,
  input  logic                 cs_n_i,
  output logic                 sdata_o,
  output logic                 sdata_oe_o,
  output logic                 sample_taken_o,
  output logic                 frame_done_o,
  output logic                 abort_o,
  output logic                 busy_o
);
  localparam int FB = LEADING_ZEROS + DATA_BITS;
  localparam int CW = $clog2(FB + 1);
  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_LAST   = CW'(FB);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(SYNC_STAGES + 1);

  edge_t cs_e, sclk_e;
  logic  unused_sclk;
  assign unused_sclk = ^{sclk_e.rise, sclk_e.level};

  ad7476a_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .async_i(cs_n_i), .edge_o(cs_e));
  ad7476a_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .async_i(sclk_i), .edge_o(sclk_e));

  state_e          state_q, state_d;
  logic [FB-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic            armed_q, armed_d;
  logic            sdata_q, sdata_d, oe_q, oe_d;
  logic            taken_q, taken_d, done_q, done_d, abort_q, abort_d;

  // The synchronizers come out of reset reading "high"; a frame may only start
  // once the chain has flushed and the real pin has been seen high, so a cs_n_i
  // held low across reset release cannot fake a falling edge.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sdata_d = sdata_q;
    oe_d    = oe_q;
    taken_d = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    flush_d = (flush_q == FLUSH_LAST) ? flush_q : flush_q + 1'b1;
    armed_d = armed_q | ((flush_q == FLUSH_LAST) & cs_e.level);
    case (state_q)
      ST_IDLE: begin
        if (cs_e.fall && armed_q) begin
          sr_d    = {{LEADING_ZEROS{1'b0}}, sample_i};
          cnt_d   = '0;
          taken_d = 1'b1;
          oe_d    = 1'b1;
          sdata_d = sr_d[FB-1];
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (sclk_e.fall) begin
          cnt_d = cnt_q + 1'b1;
          sr_d  = sr_q << 1;
        end
        if (sclk_e.fall && cnt_d == CNT_LAST) begin
          done_d  = 1'b1;
          oe_d    = 1'b0;
          sdata_d = 1'b0;
          state_d = cs_e.rise ? ST_IDLE : ST_TRAILING;
        end else if (cs_e.rise) begin
          abort_d = 1'b1;
          oe_d    = 1'b0;
          sdata_d = 1'b0;
          state_d = ST_IDLE;
        end else if (sclk_e.fall) begin
          sdata_d = sr_d[FB-1];
        end
      end
      ST_TRAILING: begin
        if (cs_e.rise) state_d = ST_IDLE;
      end
      default: begin
        oe_d    = 1'b0;
        sdata_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      armed_q <= 1'b0;
      sdata_q <= 1'b0;
      oe_q    <= 1'b0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
      sdata_q <= sdata_d;
      oe_q    <= oe_d;
      taken_q <= taken_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign sdata_o        = sdata_q;
  assign sdata_oe_o     = oe_q;
  assign sample_taken_o = taken_q;
  assign frame_done_o   = done_q;
  assign abort_o        = abort_q;
  assign busy_o         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ad7476a_responder.sv
// Self-checking bench: an SPI master model drives frames; the expected serial word
// is {4'b0, sample} and pulse counts follow from how the frame was ended.
module tb_ad7476a_responder;
  localparam int HALF = 6;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample = '0;
  logic        sclk = 1'b1;
  logic        cs_n = 1'b1;
  logic        sdata, oe, taken, done, abort_p, busy;

  int errors = 0;
  int checks = 0;
  int n_taken = 0, n_done = 0, n_abort = 0, n_bad_sdata = 0, n_overlap = 0;

  ad7476a_responder dut (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(sample), .sclk_i(sclk), .cs_n_i(cs_n),
    .sdata_o(sdata), .sdata_oe_o(oe), .sample_taken_o(taken), .frame_done_o(done),
    .abort_o(abort_p), .busy_o(busy));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_taken <= n_taken + int'(taken);
    n_done  <= n_done + int'(done);
    n_abort <= n_abort + int'(abort_p);
    if (!oe && sdata) n_bad_sdata <= n_bad_sdata + 1;
    if (int'(taken) + int'(done) + int'(abort_p) > 1) n_overlap <= n_overlap + 1;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master: cs low, then nfalls sclk cycles; bit k is sampled on the k-th rising edge
  // (bit 0 before the first fall). After the 16th fall the pad must be released.
  task automatic run_frame(input logic [11:0] s, input int nfalls,
                           output logic [15:0] got, output int oe_bad, output int late_bad);
    got = '0; oe_bad = 0; late_bad = 0;
    sample = s;
    cs_n = 1'b0;
    clk_n(HALF);
    got[15] = sdata;
    if (oe !== 1'b1) oe_bad++;
    sample = 12'($urandom);
    for (int k = 1; k <= nfalls; k++) begin
      sclk = 1'b0;
      clk_n(HALF);
      sclk = 1'b1;
      if (k < 16) begin
        got[15-k] = sdata;
        if (oe !== 1'b1) oe_bad++;
      end else if (oe !== 1'b0 || sdata !== 1'b0) late_bad++;
      clk_n(HALF);
    end
  endtask

  task automatic cs_release();
    cs_n = 1'b1;
    clk_n(HALF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_n(3);
    checks++;
    if ({oe, sdata, taken, done, abort_p, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000", {oe, sdata, taken, done, abort_p, busy});
    end
    rst_n = 1'b1;
    clk_n(8);
    checks++;
    if (busy !== 1'b0 || oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b oe=%b required 0 0", busy, oe);
    end
  endtask

  task automatic test_frames();
    logic [15:0] got;
    logic [11:0] s;
    int ob, lb, t0, d0, a0;
    for (int i = 0; i < 6; i++) begin
      s = (i == 0) ? 12'hA5C : 12'($urandom);
      t0 = n_taken; d0 = n_done; a0 = n_abort;
      run_frame(s, 16, got, ob, lb);
      checks++;
      if (got !== {4'b0, s} || ob != 0 || lb != 0) begin
        errors++;
        $display("FAIL frame_word: got %h oe_bad=%0d late_bad=%0d required %h 0 0", got, ob, lb, {4'b0, s});
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL trailing_busy: got %b required 1", busy);
      end
      cs_release();
      checks++;
      if (busy !== 1'b0 || n_taken - t0 != 1 || n_done - d0 != 1 || n_abort - a0 != 0) begin
        errors++;
        $display("FAIL frame_pulses: busy=%b taken=%0d done=%0d abort=%0d required 0 1 1 0",
                 busy, n_taken - t0, n_done - d0, n_abort - a0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g0, g1;
    int ob0, lb0, ob1, lb1, t0, d0;
    t0 = n_taken; d0 = n_done;
    run_frame(12'h000, 16, g0, ob0, lb0);
    cs_release();
    run_frame(12'hFFF, 16, g1, ob1, lb1);
    cs_release();
    checks++;
    if (g0 !== 16'h0000 || g1 !== 16'h0FFF || ob0 + lb0 + ob1 + lb1 != 0) begin
      errors++;
      $display("FAIL b2b_words: got %h %h required 0000 0fff", g0, g1);
    end
    checks++;
    if (n_taken - t0 != 2 || n_done - d0 != 2) begin
      errors++;
      $display("FAIL b2b_pulses: taken=%0d done=%0d required 2 2", n_taken - t0, n_done - d0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] got, exp;
    logic [11:0] s1, s2;
    int ob, lb, d0, a0;
    s1 = 12'($urandom); s2 = ~s1;
    exp = {4'b0, s1};
    d0 = n_done; a0 = n_abort;
    run_frame(s1, 7, got, ob, lb);
    cs_n = 1'b1;
    clk_n(4);
    checks++;
    if (oe !== 1'b0 || busy !== 1'b0 || n_abort - a0 != 1 || n_done - d0 != 0) begin
      errors++;
      $display("FAIL abort: oe=%b busy=%b abort=%0d done=%0d required 0 0 1 0",
               oe, busy, n_abort - a0, n_done - d0);
    end
    checks++;
    if (got[15:8] !== exp[15:8] || ob != 0) begin
      errors++;
      $display("FAIL abort_partial: got %h required %h", got[15:8], exp[15:8]);
    end
    clk_n(HALF);
    run_frame(s2, 16, got, ob, lb);
    cs_release();
    checks++;
    if (got !== {4'b0, s2}) begin
      errors++;
      $display("FAIL after_abort_word: got %h required %h", got, {4'b0, s2});
    end
  endtask

  task automatic test_overrun();
    logic [15:0] got;
    logic [11:0] s;
    int ob, lb, d0, a0;
    s = 12'($urandom);
    d0 = n_done; a0 = n_abort;
    run_frame(s, 20, got, ob, lb);
    checks++;
    if (got !== {4'b0, s} || ob != 0 || lb != 0) begin
      errors++;
      $display("FAIL overrun_word: got %h late_bad=%0d required %h 0", got, lb, {4'b0, s});
    end
    cs_release();
    checks++;
    if (busy !== 1'b0 || n_done - d0 != 1 || n_abort - a0 != 0) begin
      errors++;
      $display("FAIL overrun_pulses: busy=%b done=%0d abort=%0d required 0 1 0",
               busy, n_done - d0, n_abort - a0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    logic [11:0] s;
    int ob, lb, t0;
    s = 12'($urandom);
    sample = s;
    cs_n = 1'b0;
    clk_n(HALF);
    for (int k = 1; k <= 9; k++) begin
      sclk = 1'b0; clk_n(HALF); sclk = 1'b1; clk_n(HALF);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({oe, sdata, taken, done, abort_p, busy} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b required 000000", {oe, sdata, taken, done, abort_p, busy});
    end
    clk_n(2);
    rst_n = 1'b1;
    t0 = n_taken;
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b0; clk_n(HALF); sclk = 1'b1; clk_n(HALF);
    end
    checks++;
    if (oe !== 1'b0 || busy !== 1'b0 || n_taken - t0 != 0) begin
      errors++;
      $display("FAIL cs_low_at_release: oe=%b busy=%b taken=%0d required 0 0 0", oe, busy, n_taken - t0);
    end
    cs_release();
    run_frame(s ^ 12'h5A5, 16, got, ob, lb);
    cs_release();
    checks++;
    if (got !== {4'b0, s ^ 12'h5A5}) begin
      errors++;
      $display("FAIL post_reset_word: got %h required %h", got, {4'b0, s ^ 12'h5A5});
    end
  endtask

  task automatic test_idle_sclk();
    int bad, t0, d0, a0;
    bad = 0; t0 = n_taken; d0 = n_done; a0 = n_abort;
    cs_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sclk = 1'b0; clk_n(HALF);
      if (oe !== 1'b0 || busy !== 1'b0) bad++;
      sclk = 1'b1; clk_n(HALF);
    end
    checks++;
    if (bad != 0 || n_taken - t0 + n_done - d0 + n_abort - a0 != 0) begin
      errors++;
      $display("FAIL idle_sclk: bad=%0d pulses=%0d required 0 0", bad, n_taken - t0 + n_done - d0 + n_abort - a0);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (n_bad_sdata != 0 || n_overlap != 0) begin
      errors++;
      $display("FAIL invariants: sdata_without_oe=%0d overlapping_pulses=%0d required 0 0",
               n_bad_sdata, n_overlap);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_mid();
    test_idle_sclk();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
